seg7_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for the clock's common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment display. One shared seg7 decoder serves N_DIGITS digits; each
// digit slot opens with BLANK_CYC dark cycles (anti-ghosting) and is then lit
// for the rest of SCAN_DIV cycles. Digits are snapshotted once per frame.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   en          1 = scan, 0 = display dark
//   din         BCD digits, digit i = din[4i+3:4i]; 4'hF = blank code
//   dp_in       decimal point request per digit, 1 = lit
//   blank_mask  1 = digit forced dark (live)
//   blink_mask  1 = digit dark during blink off-phase (live)
//   an          anode enables, active-low
//   seg         segments {a,b,c,d,e,f,g}, active-low
//   dp          decimal point, active-low
//   frame_tick  1-cycle pulse when a frame starts (digit 0 slot, snapshot taken)

// seg7: BCD to active-low {a,b,c,d,e,f,g}; codes A..F render "0".
module seg7 (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd1:    o_seg = 7'b100_1111;
      4'd2:    o_seg = 7'b001_0010;
      4'd3:    o_seg = 7'b000_0110;
      4'd4:    o_seg = 7'b100_1100;
      4'd5:    o_seg = 7'b010_0100;
      4'd6:    o_seg = 7'b010_0000;
      4'd7:    o_seg = 7'b000_1111;
      4'd8:    o_seg = 7'b000_0000;
      4'd9:    o_seg = 7'b000_0100;
      default: o_seg = 7'b000_0001;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t                r_state, w_state_nx;
  logic [SW-1:0]         r_slot, w_slot_nx;
  logic [IW-1:0]         r_idx, w_idx_nx;
  logic                  w_snap_ld, w_tick_nx;
  logic [4*N_DIGITS-1:0] r_snap;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic [BW-1:0]         r_blink;
  logic                  r_blink_on;
  logic [3:0]            w_digit;
  logic [6:0]            w_seg;
  logic                  w_dark;
  logic [N_DIGITS-1:0]   w_an_nx;
  logic [6:0]            w_seg_nx;
  logic                  w_dp_nx;

  assign w_digit = r_snap[{r_idx, 2'b00} +: 4];

  seg7 u_seg7 (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Next-state, slot/digit counters and snapshot/tick strobes.
  always_comb begin
    w_state_nx = r_state;
    w_slot_nx  = r_slot;
    w_idx_nx   = r_idx;
    w_snap_ld  = 1'b0;
    w_tick_nx  = 1'b0;
    if (!en) begin
      w_state_nx = S_IDLE;
      w_slot_nx  = '0;
      w_idx_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_BLANK;
          w_slot_nx  = '0;
          w_idx_nx   = '0;
          w_snap_ld  = 1'b1;
          w_tick_nx  = 1'b1;
        end
        S_BLANK: begin
          w_slot_nx = r_slot + 1'b1;
          if (r_slot == BLANK_LAST) w_state_nx = S_DRIVE;
        end
        S_DRIVE: begin
          if (r_slot == SLOT_LAST) begin
            w_slot_nx  = '0;
            w_state_nx = S_BLANK;
            if (r_idx == IDX_LAST) begin
              w_idx_nx  = '0;
              w_snap_ld = 1'b1;
              w_tick_nx = 1'b1;
            end else begin
              w_idx_nx = r_idx + 1'b1;
            end
          end else begin
            w_slot_nx = r_slot + 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Output selection from the current state; registered below so pins lag
  // the selecting state by one cycle. en=0 darkens on the very next edge.
  always_comb begin
    w_dark   = blank_mask[r_idx] || (w_digit == 4'hF) ||
               (blink_mask[r_idx] && !r_blink_on);
    w_an_nx  = '1;
    w_seg_nx = '1;
    w_dp_nx  = 1'b1;
    if (en && (r_state == S_DRIVE) && !w_dark) begin
      w_an_nx[r_idx] = 1'b0;
      w_seg_nx       = w_seg;
      w_dp_nx        = ~r_snap_dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_slot  <= w_slot_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap    <= '0;
      r_snap_dp <= '0;
    end else if (w_snap_ld) begin
      r_snap    <= din;
      r_snap_dp <= dp_in;
    end
  end

  // Blink phase only advances while actively scanning.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || (r_state == S_IDLE)) begin
      r_blink    <= '0;
      r_blink_on <= 1'b1;
    end else if (r_blink == BLINK_LAST) begin
      r_blink    <= '0;
      r_blink_on <= ~r_blink_on;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an_nx;
      seg        <= w_seg_nx;
      dp         <= w_dp_nx;
      frame_tick <= w_tick_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2,
// BLINK_DIV=64. "o" is the output cycle index: o=0 is the cycle frame_tick
// first rises; pins at cycle o reflect scan state o-1.
module tb_seg7_scan_ctrl;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [6:0] S0 = 7'b000_0001, S1 = 7'b100_1111, S2 = 7'b001_0010,
                         S3 = 7'b000_0110, S4 = 7'b100_1100, S8 = 7'b000_0000,
                         S9 = 7'b000_0100, SOFF = 7'b111_1111;

  seg7_scan_ctrl #(
    .N_DIGITS  (4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .BLINK_DIV (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"},  16'(an),  16'(e_an));
    chk({tag, ".seg"}, 16'(seg), 16'(e_seg));
    chk({tag, ".dp"},  16'(dp),  16'(e_dp));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 16'h0000; dp_in = 4'b0000;
    blank_mask = 4'b0000; blink_mask = 4'b0000;
    go(3);
    chk_pins("reset", 4'hF, SOFF, 1'b1);
    chk("reset.ft", 16'(frame_tick), 16'd0);

    // Test 1: basic scan of 1234
    rst_n = 1'b1; en = 1'b1; din = 16'h1234;
    go(1);                                   // o=0
    chk("t1.ft0", 16'(frame_tick), 16'd1);
    chk_pins("t1.o0", 4'hF, SOFF, 1'b1);
    go(1);                                   // o=1
    chk("t1.ft1", 16'(frame_tick), 16'd0);
    go(1);                                   // o=2
    chk_pins("t1.o2", 4'hF, SOFF, 1'b1);
    go(1);                                   // o=3
    chk_pins("t1.d0", 4'b1110, S4, 1'b1);

    // Test 2: din change mid-frame must not tear the current frame
    din = 16'h5678;
    go(5);                                   // o=8, last lit cycle of digit 0
    chk_pins("t1.d0end", 4'b1110, S4, 1'b1);
    go(1);                                   // o=9
    chk_pins("t1.gap", 4'hF, SOFF, 1'b1);
    go(2);                                   // o=11
    chk_pins("t2.d1", 4'b1101, S3, 1'b1);
    go(8);                                   // o=19
    chk_pins("t2.d2", 4'b1011, S2, 1'b1);
    go(8);                                   // o=27
    chk_pins("t2.d3", 4'b0111, S1, 1'b1);
    go(4);                                   // o=31
    chk("t2.ft31", 16'(frame_tick), 16'd0);
    go(1);                                   // o=32
    chk("t2.ft32", 16'(frame_tick), 16'd1);
    go(3);                                   // o=35
    chk_pins("t2.d0new", 4'b1110, S8, 1'b1);

    // Test 3: blank code and blank_mask
    din = 16'hF9F0; blank_mask = 4'b0010;
    go(29);                                  // o=64
    chk("t3.ft64", 16'(frame_tick), 16'd1);
    go(3);                                   // o=67
    chk_pins("t3.d0", 4'b1110, S0, 1'b1);
    go(8);                                   // o=75
    chk_pins("t3.d1", 4'hF, SOFF, 1'b1);
    go(8);                                   // o=83
    chk_pins("t3.d2", 4'b1011, S9, 1'b1);
    go(8);                                   // o=91
    chk_pins("t3.d3", 4'hF, SOFF, 1'b1);

    // Test 4: blink on digit 0; scan states 64..127 are the off-phase
    blink_mask = 4'b0001;
    go(8);                                   // o=99
    chk_pins("t4.off", 4'hF, SOFF, 1'b1);
    go(16);                                  // o=115
    chk_pins("t4.d2", 4'b1011, S9, 1'b1);
    go(16);                                  // o=131
    chk_pins("t4.on", 4'b1110, S0, 1'b1);

    // Test 5: decimal point on digit 2 only
    din = 16'h1234; dp_in = 4'b0100; blank_mask = 4'b0000; blink_mask = 4'b0000;
    go(32);                                  // o=163
    chk_pins("t5.d0", 4'b1110, S4, 1'b1);
    go(14);                                  // o=177, digit 2 blank window
    chk_pins("t5.gap", 4'hF, SOFF, 1'b1);
    go(2);                                   // o=179
    chk_pins("t5.d2", 4'b1011, S2, 1'b0);

    // Test 6: drop en mid-DRIVE of digit 2, then re-enable
    go(1);                                   // o=180
    en = 1'b0;
    go(1);
    chk_pins("t6.off", 4'hF, SOFF, 1'b1);
    go(2);
    chk_pins("t6.off2", 4'hF, SOFF, 1'b1);
    chk("t6.ftoff", 16'(frame_tick), 16'd0);
    en = 1'b1;
    go(1);
    chk("t6.ft", 16'(frame_tick), 16'd1);
    go(2);
    chk_pins("t6.dark", 4'hF, SOFF, 1'b1);
    go(1);
    chk_pins("t6.d0", 4'b1110, S4, 1'b1);

    // Reset mid-frame with en still high
    go(10);
    rst_n = 1'b0;
    go(1);
    chk_pins("t6.rst", 4'hF, SOFF, 1'b1);
    chk("t6.rstft", 16'(frame_tick), 16'd0);
    rst_n = 1'b1;
    go(1);
    chk("t6.rstrel", 16'(frame_tick), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
